pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 27 ++
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the dual-issue pipeline: FSM states, issue masks and ALU op codes.
package pipeline_ctrl_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_SPLIT = 1'b1
   } state_t;

   localparam logic [1:0] ISSUE_NONE = 2'b00;
   localparam logic [1:0] ISSUE_S1   = 2'b01;
   localparam logic [1:0] ISSUE_S2   = 2'b10;
   localparam logic [1:0] ISSUE_BOTH = 2'b11;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SLL  = 4'h5,
      ALU_SRL  = 4'h6,
      ALU_SRA  = 4'h7,
      ALU_SLT  = 4'h8,
      ALU_SLTU = 4'h9
   } alu_op_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high clear.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/issue controller for a two-slot in-order pipeline, with perf counters
// and a sticky data-memory timeout flag.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_raw_1,
   input  logic             stall_raw_2,
   input  logic             intra_dep,
   input  logic             mem_busy,
   input  logic             br_taken,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       issue_mask,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic             err_timeout
);

   localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

   state_t          state_q;
   state_t          state_d;
   logic            flush_inc;
   logic            stall_inc;
   logic [TO_W-1:0] busy_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Priority: reset, memory freeze, branch flush, then hazard/split handling.
   always_comb begin
      state_d     = state_q;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      issue_mask  = ISSUE_NONE;
      flush_inc   = 1'b0;
      if (rst) begin
         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         state_d     = ST_RUN;
      end else if (mem_busy) begin
         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
      end else if (br_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         flush_inc   = 1'b1;
         state_d     = ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (stall_raw_1) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end else if (stall_raw_2 || intra_dep) begin
                  pc_en      = 1'b0;
                  if_id_en   = 1'b0;
                  issue_mask = ISSUE_S1;
                  state_d    = ST_SPLIT;
               end else begin
                  issue_mask = ISSUE_BOTH;
               end
            end
            ST_SPLIT: begin
               if (stall_raw_2) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end else begin
                  issue_mask = ISSUE_S2;
                  state_d    = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   assign stall_inc = ~pc_en & ~rst;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .q   (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_inc),
      .q   (flush_count)
   );

   // Consecutive-busy run length; flag latches on the edge the run reaches MEM_TIMEOUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_cnt    <= '0;
         err_timeout <= 1'b0;
      end else if (mem_busy) begin
         if (busy_cnt != TO_W'(MEM_TIMEOUT)) begin
            busy_cnt <= busy_cnt + TO_W'(1);
         end
         if (busy_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
         end
      end else begin
         busy_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus queues expected outputs, a negedge monitor checks them.
module tb_pipeline_ctrl;

   localparam int unsigned CNT_W = 4;

   // Input vector order: {rst, raw1, raw2, intra, busy, br}
   localparam logic [5:0] I_NONE = 6'b000000;
   localparam logic [5:0] I_RST  = 6'b100000;
   localparam logic [5:0] I_R1   = 6'b010000;
   localparam logic [5:0] I_R2   = 6'b001000;
   localparam logic [5:0] I_ID   = 6'b000100;
   localparam logic [5:0] I_MB   = 6'b000010;
   localparam logic [5:0] I_BR   = 6'b000001;

   // Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, mask[1:0]}
   localparam logic [8:0] C_RUN    = 9'b11111_00_11;
   localparam logic [8:0] C_FREEZE = 9'b00000_00_00;
   localparam logic [8:0] C_BR     = 9'b11111_11_00;
   localparam logic [8:0] C_STALL  = 9'b00111_01_00;
   localparam logic [8:0] C_SPLIT1 = 9'b00111_00_01;
   localparam logic [8:0] C_SPLIT2 = 9'b11111_00_10;
   localparam logic [8:0] C_RST    = 9'b00000_11_00;

   typedef struct {
      string      name;
      logic [8:0] ctl;
      logic       err;
      bit         chk;
      logic [3:0] st;
      logic [3:0] fl;
   } exp_t;

   logic clk = 1'b0;
   logic rst, stall_raw_1, stall_raw_2, intra_dep, mem_busy, br_taken;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
   logic [1:0] issue_mask;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   logic err_timeout;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(255)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_raw_1  (stall_raw_1),
      .stall_raw_2  (stall_raw_2),
      .intra_dep    (intra_dep),
      .mem_busy     (mem_busy),
      .br_taken     (br_taken),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .id_ex_en     (id_ex_en),
      .ex_mem_en    (ex_mem_en),
      .mem_wb_en    (mem_wb_en),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .issue_mask   (issue_mask),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count),
      .err_timeout  (err_timeout)
   );

   // Drive one cycle of inputs and queue what the outputs must be during that cycle.
   task automatic step(input string nm, input logic [5:0] in, input logic [8:0] ctl,
                       input logic err, input bit chk, input logic [3:0] st, input logic [3:0] fl);
      exp_t e;
      {rst, stall_raw_1, stall_raw_2, intra_dep, mem_busy, br_taken} = in;
      e.name = nm; e.ctl = ctl; e.err = err; e.chk = chk; e.st = st; e.fl = fl;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [8:0] act;
         e   = sb.pop_front();
         act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, issue_mask};
         total++;
         if (act === e.ctl) passed++;
         else $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
         total++;
         if (err_timeout === e.err) passed++;
         else $display("FAIL %s err_timeout: got %b want %b", e.name, err_timeout, e.err);
         if (e.chk) begin
            total++;
            if (stall_cycles === e.st) passed++;
            else $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.st);
            total++;
            if (flush_count === e.fl) passed++;
            else $display("FAIL %s flush_count: got %0d want %0d", e.name, flush_count, e.fl);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

   initial begin
      {rst, stall_raw_1, stall_raw_2, intra_dep, mem_busy, br_taken} = I_RST;
      @(posedge clk);
      #1;
      step("reset",      I_RST,  C_RST,    1'b0, 1, 4'd0, 4'd0);

      // Single load-use stall on slot 1
      step("idle0",      I_NONE, C_RUN,    1'b0, 1, 4'd0, 4'd0);
      step("raw1",       I_R1,   C_STALL,  1'b0, 1, 4'd0, 4'd0);
      step("raw1_after", I_NONE, C_RUN,    1'b0, 1, 4'd1, 4'd0);

      // Intra-pair dependency splits the pair
      step("intra",      I_ID,   C_SPLIT1, 1'b0, 1, 4'd1, 4'd0);
      step("split2",     I_NONE, C_SPLIT2, 1'b0, 1, 4'd2, 4'd0);
      step("back_run",   I_NONE, C_RUN,    1'b0, 1, 4'd2, 4'd0);

      // SPLIT ignores raw1/intra; raw2 holds in SPLIT
      step("intra_b",    I_ID,        C_SPLIT1, 1'b0, 1, 4'd2, 4'd0);
      step("split_ign",  I_ID | I_R1, C_SPLIT2, 1'b0, 1, 4'd3, 4'd0);
      step("raw2_run",   I_R2,        C_SPLIT1, 1'b0, 1, 4'd3, 4'd0);
      step("raw2_split", I_R2,        C_STALL,  1'b0, 1, 4'd4, 4'd0);
      step("split2_b",   I_NONE,      C_SPLIT2, 1'b0, 1, 4'd5, 4'd0);
      step("run_b",      I_NONE,      C_RUN,    1'b0, 1, 4'd5, 4'd0);

      // Branch in SPLIT cancels pending slot 2
      step("intra_c",    I_ID,   C_SPLIT1, 1'b0, 1, 4'd5, 4'd0);
      step("br_split",   I_BR,   C_BR,     1'b0, 1, 4'd6, 4'd0);
      step("br_after",   I_NONE, C_RUN,    1'b0, 1, 4'd6, 4'd1);

      // mem_busy outranks branch; flush taken when busy drops
      step("rst_d",      I_RST,  C_RST,    1'b0, 0, 4'd0, 4'd0);
      step("mb_br0",     I_MB | I_BR, C_FREEZE, 1'b0, 1, 4'd0, 4'd0);
      step("mb_br1",     I_MB | I_BR, C_FREEZE, 1'b0, 1, 4'd1, 4'd0);
      step("mb_br2",     I_MB | I_BR, C_FREEZE, 1'b0, 1, 4'd2, 4'd0);
      step("br_release", I_BR,        C_BR,     1'b0, 1, 4'd3, 4'd0);
      step("br_done",    I_NONE,      C_RUN,    1'b0, 1, 4'd3, 4'd1);

      // mem_busy freezes SPLIT in place
      step("intra_d",    I_ID,   C_SPLIT1, 1'b0, 1, 4'd3, 4'd1);
      step("mb_split",   I_MB,   C_FREEZE, 1'b0, 1, 4'd4, 4'd1);
      step("split2_d",   I_NONE, C_SPLIT2, 1'b0, 1, 4'd5, 4'd1);
      step("run_d",      I_NONE, C_RUN,    1'b0, 1, 4'd5, 4'd1);

      // Reset mid-SPLIT drops slot 2
      step("intra_e",    I_ID,   C_SPLIT1, 1'b0, 1, 4'd5, 4'd1);
      step("rst_split",  I_RST,  C_RST,    1'b0, 0, 4'd0, 4'd0);
      step("post_rst",   I_NONE, C_RUN,    1'b0, 1, 4'd0, 4'd0);

      // Stall counter saturation at 15 with CNT_W=4
      for (int i = 0; i < 20; i++) begin
         step("sat_stall", I_R1, C_STALL, 1'b0, 1, (i > 15) ? 4'd15 : 4'(i), 4'd0);
      end
      step("sat_hold",   I_NONE, C_RUN,    1'b0, 1, 4'd15, 4'd0);
      step("rst_sat",    I_RST,  C_RST,    1'b0, 0, 4'd0, 4'd0);
      step("sat_clear",  I_NONE, C_RUN,    1'b0, 1, 4'd0, 4'd0);

      // Busy runs of 254 separated by an idle cycle never time out
      for (int i = 0; i < 254; i++) step("busy254a", I_MB, C_FREEZE, 1'b0, 0, 4'd0, 4'd0);
      step("gap",        I_NONE, C_RUN,    1'b0, 0, 4'd0, 4'd0);
      for (int i = 0; i < 254; i++) step("busy254b", I_MB, C_FREEZE, 1'b0, 0, 4'd0, 4'd0);
      step("gap2",       I_NONE, C_RUN,    1'b0, 0, 4'd0, 4'd0);

      // 255 consecutive busy cycles set the sticky flag
      for (int i = 0; i < 255; i++) step("busy255", I_MB, C_FREEZE, 1'b0, 0, 4'd0, 4'd0);
      step("to_set",     I_NONE, C_RUN,    1'b1, 0, 4'd0, 4'd0);
      step("to_sticky",  I_NONE, C_RUN,    1'b1, 0, 4'd0, 4'd0);
      step("to_sticky2", I_MB,   C_FREEZE, 1'b1, 0, 4'd0, 4'd0);
      step("rst_to",     I_RST,  C_RST,    1'b1, 0, 4'd0, 4'd0);
      step("to_clear",   I_NONE, C_RUN,    1'b0, 1, 4'd0, 4'd0);

      @(posedge clk);
      @(posedge clk);
      total++;
      if (sb.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending entries want 0", sb.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
